// File: rtl/uart_pkg.sv
// Shared UART register map: bus offsets, STATUS/CTRL bit positions and word packers.
// Reused by the RX controller now and intended for the TX controller later.
package uart_pkg;

  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_RX_EN     = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_RX_EN      = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_FLUSH      = 2;
  localparam int CTRL_THRESH_LSB = 8;

  // Count/thresh fields are at most 5 bits wide (DEPTH <= 16), so an 8-bit slot is ample.
  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic       rx_en,
                                              input logic [7:0] count);
    logic [31:0] w;
    w                         = '0;
    w[ST_EMPTY]               = empty;
    w[ST_FULL]                = full;
    w[ST_OVERFLOW]            = overflow;
    w[ST_RX_EN]               = rx_en;
    w[ST_COUNT_LSB +: 8]      = count;
    return w;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic       rx_en,
                                            input logic       irq_en,
                                            input logic [7:0] thresh);
    logic [31:0] w;
    w                         = '0;
    w[CTRL_RX_EN]             = rx_en;
    w[CTRL_IRQ_EN]            = irq_en;
    w[CTRL_THRESH_LSB +: 8]   = thresh;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus and receiver-strobe bundle for the UART receive controller.
// master = CPU bus plus UART_Rx side, slave = the controller.
interface uart_rx_ctrl_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Sel;
  logic        i_Rd;
  logic        i_Wr;
  logic [1:0]  i_Addr;
  logic [31:0] i_Wdata;
  logic [31:0] o_Rdata;
  logic        o_Irq;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Sel, i_Rd, i_Wr, i_Addr, i_Wdata,
    input  o_Rdata, o_Irq
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Sel, i_Rd, i_Wr, i_Addr, i_Wdata,
    output o_Rdata, o_Irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through output and same-cycle push/pop.
// A pop frees the head slot before the push is judged, so push at full with pop is accepted.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset: contents are only visible through count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge i_Clock) begin
      if (push_ok && (wr_ptr_reg == AW'(gi))) mem[gi] <= din;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped UART receive controller: RX FIFO, STATUS/CTRL registers,
// registered read data and a level interrupt on fill threshold or dropped bytes.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  uart_rx_ctrl_if.slave  bus
);

  logic          rx_en_reg, rx_en_next;
  logic          irq_en_reg, irq_en_next;
  logic [AW:0]   thresh_reg, thresh_next;
  logic          overflow_reg, overflow_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          irq_reg, irq_next;

  logic          rd_req;
  logic          wr_req;
  logic          ctrl_wr;
  logic          flush;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_w1c;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // A write wins over a simultaneous read, which is then dropped entirely.
  assign rd_req  = bus.i_Sel & bus.i_Rd & ~bus.i_Wr;
  assign wr_req  = bus.i_Sel & bus.i_Wr;
  assign ctrl_wr = wr_req & (bus.i_Addr == ADDR_CTRL);
  assign flush   = ctrl_wr & bus.i_Wdata[CTRL_FLUSH];
  assign pop     = rd_req & (bus.i_Addr == ADDR_RXDATA);
  assign push    = bus.i_Rx_DV & rx_en_reg;
  assign ovf_set = push & fifo_full & ~pop & ~flush;
  assign ovf_w1c = wr_req & (bus.i_Addr == ADDR_STATUS) & bus.i_Wdata[ST_OVERFLOW];

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (bus.i_Rx_Byte),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    rx_en_next    = rx_en_reg;
    irq_en_next   = irq_en_reg;
    thresh_next   = thresh_reg;
    overflow_next = overflow_reg;
    rdata_next    = rdata_reg;

    if (ctrl_wr) begin
      rx_en_next  = bus.i_Wdata[CTRL_RX_EN];
      irq_en_next = bus.i_Wdata[CTRL_IRQ_EN];
      thresh_next = bus.i_Wdata[CTRL_THRESH_LSB +: AW+1];
    end

    // Flush beats a new drop, and a new drop beats the W1C clear.
    if (flush)        overflow_next = 1'b0;
    else if (ovf_set) overflow_next = 1'b1;
    else if (ovf_w1c) overflow_next = 1'b0;

    if (rd_req) begin
      case (bus.i_Addr)
        ADDR_RXDATA: rdata_next = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
        ADDR_STATUS: rdata_next = status_word(fifo_empty, fifo_full, overflow_reg,
                                              rx_en_reg, 8'(fifo_count));
        ADDR_CTRL:   rdata_next = ctrl_word(rx_en_reg, irq_en_reg, 8'(thresh_reg));
        default:     rdata_next = 32'd0;
      endcase
    end
  end

  // Both compare operands are AW+1 bits wide, so thresh above DEPTH can never match.
  assign irq_next = irq_en_reg &
                    (((fifo_count >= thresh_reg) & (thresh_reg != '0)) | overflow_reg);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_en_reg    <= 1'b1;
      irq_en_reg   <= 1'b0;
      thresh_reg   <= (AW+1)'(1);
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      rx_en_reg    <= rx_en_next;
      irq_en_reg   <= irq_en_next;
      thresh_reg   <= thresh_next;
      overflow_reg <= overflow_next;
      rdata_reg    <= rdata_next;
      irq_reg      <= irq_next;
    end
  end

  assign bus.o_Rdata = rdata_reg;
  assign bus.o_Irq   = irq_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a vector table, directed corner sequences and a randomized
// run, all checked against a queue-based register model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic i_Clock = 1'b0;
  logic i_Rst_n = 1'b0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int n_vec  = 0;
  int n_err  = 0;
  bit verbose = 1'b1;

  // Reference model: bytes held as a queue, registers as plain variables.
  bit [7:0]  q[$];
  bit        m_ovf;
  bit        m_rx_en;
  bit        m_irq_en;
  bit [3:0]  m_thresh;
  bit [31:0] m_rdata;
  bit        m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit dv, input bit [7:0] b, input bit s, input bit r,
                            input bit w, input bit [1:0] a, input bit [31:0] wd);
    bit rd_q, wr_q, set_q;
    int n;
    if (!i_Rst_n) begin
      q.delete();
      m_ovf = 0; m_rx_en = 1; m_irq_en = 0; m_thresh = 1; m_rdata = 0; m_irq = 0;
      return;
    end
    n    = q.size();
    rd_q = s && r && !w;
    wr_q = s && w;
    m_irq = m_irq_en && (((n >= int'(m_thresh)) && (m_thresh != 0)) || m_ovf);
    if (rd_q) begin
      m_rdata = 0;
      case (a)
        2'd0: if (n > 0) m_rdata[7:0] = q[0];
        2'd1: begin
          m_rdata[0]    = (n == 0);
          m_rdata[1]    = (n == DEPTH);
          m_rdata[2]    = m_ovf;
          m_rdata[3]    = m_rx_en;
          m_rdata[11:8] = 4'(n);
        end
        2'd2: begin
          m_rdata[0]    = m_rx_en;
          m_rdata[1]    = m_irq_en;
          m_rdata[11:8] = m_thresh;
        end
        default: m_rdata = 0;
      endcase
    end
    if (wr_q && a == 2'd2 && wd[2]) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (rd_q && a == 2'd0 && n > 0) void'(q.pop_front());
      set_q = 0;
      if (dv && m_rx_en) begin
        if (q.size() < DEPTH) q.push_back(b);
        else begin m_ovf = 1; set_q = 1; end
      end
      if (wr_q && a == 2'd1 && wd[2] && !set_q) m_ovf = 0;
    end
    if (wr_q && a == 2'd2) begin
      m_rx_en  = wd[0];
      m_irq_en = wd[1];
      m_thresh = wd[11:8];
    end
  endtask

  // One bus/receiver cycle: drive, advance the model, clock, compare after the edge.
  task automatic drive(input bit dv, input bit [7:0] b, input bit s, input bit r,
                       input bit w, input bit [1:0] a, input bit [31:0] wd);
    bus.i_Rx_DV   = dv;
    bus.i_Rx_Byte = b;
    bus.i_Sel     = s;
    bus.i_Rd      = r;
    bus.i_Wr      = w;
    bus.i_Addr    = a;
    bus.i_Wdata   = wd;
    model_step(dv, b, s, r, w, a, wd);
    @(posedge i_Clock);
    #1;
    if (verbose)
      $display("txn rst_n=%0b dv=%0b byte=%02h sel=%0b rd=%0b wr=%0b addr=%0d wdata=%08h -> rdata=%08h irq=%0b",
               i_Rst_n, dv, b, s, r, w, a, wd, bus.o_Rdata, bus.o_Irq);
    check("rdata", bus.o_Rdata, m_rdata);
    check("irq", {31'd0, bus.o_Irq}, {31'd0, m_irq});
  endtask

  task automatic idle();               drive(0, 8'h00, 0, 0, 0, 2'd0, 32'd0); endtask
  task automatic push(input bit [7:0] b); drive(1, b, 0, 0, 0, 2'd0, 32'd0); endtask
  task automatic rd(input bit [1:0] a);   drive(0, 8'h00, 1, 1, 0, a, 32'd0); endtask
  task automatic wr(input bit [1:0] a, input bit [31:0] d); drive(0, 8'h00, 1, 0, 1, a, d); endtask

  task automatic do_reset();
    i_Rst_n = 1'b0;
    idle();
    i_Rst_n = 1'b1;
  endtask

  typedef struct {
    bit        dv;
    bit [7:0]  b;
    bit        rd;
    bit [1:0]  a;
    bit [31:0] exp_rdata;
    bit        exp_irq;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bus.i_Rx_DV = 0; bus.i_Rx_Byte = 0; bus.i_Sel = 0; bus.i_Rd = 0;
    bus.i_Wr = 0; bus.i_Addr = 0; bus.i_Wdata = 0;

    // Reset values
    do_reset();
    check("reset_rdata", bus.o_Rdata, 32'd0);
    check("reset_irq", {31'd0, bus.o_Irq}, 32'd0);
    rd(2'd2);
    check("reset_ctrl", bus.o_Rdata, 32'h0000_0101);

    // Three bytes in, three out, then STATUS back to empty with rx_en
    tbl[0] = '{1, 8'h41, 0, 2'd0, 32'h0000_0101, 0};
    tbl[1] = '{1, 8'h42, 0, 2'd0, 32'h0000_0101, 0};
    tbl[2] = '{1, 8'h43, 0, 2'd0, 32'h0000_0101, 0};
    tbl[3] = '{0, 8'h00, 1, 2'd0, 32'h0000_0041, 0};
    tbl[4] = '{0, 8'h00, 1, 2'd0, 32'h0000_0042, 0};
    tbl[5] = '{0, 8'h00, 1, 2'd0, 32'h0000_0043, 0};
    tbl[6] = '{0, 8'h00, 1, 2'd1, 32'h0000_0009, 0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].dv, tbl[i].b, tbl[i].rd, tbl[i].rd, 0, tbl[i].a, 32'd0);
      check($sformatf("tbl%0d_rdata", i), bus.o_Rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_irq", i), {31'd0, bus.o_Irq}, {31'd0, tbl[i].exp_irq});
    end

    // Overfill: ninth byte dropped, overflow sticky
    for (int i = 0; i < 8; i++) push(8'(i));
    push(8'hFF);
    rd(2'd1);
    check("ovf_status", bus.o_Rdata, 32'h0000_080E);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0);
      check($sformatf("ovf_read%0d", i), bus.o_Rdata, 32'(i));
    end
    rd(2'd1);
    check("ovf_drained", bus.o_Rdata, 32'h0000_000D);
    wr(2'd1, 32'h4);

    // Push and pop together at full: no overflow, 0xAA ends up last
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    drive(1, 8'hAA, 1, 1, 0, 2'd0, 32'd0);
    check("fullpp_head", bus.o_Rdata, 32'h10);
    rd(2'd1);
    check("fullpp_status", bus.o_Rdata, 32'h0000_080A);
    for (int i = 1; i < 8; i++) rd(2'd0);
    check("fullpp_b7", bus.o_Rdata, 32'h17);
    rd(2'd0);
    check("fullpp_last", bus.o_Rdata, 32'hAA);
    rd(2'd0);
    check("empty_read", bus.o_Rdata, 32'h0);

    // Threshold interrupt at 3 bytes
    wr(2'd2, 32'h0000_0303);
    push(8'h01); push(8'h02); idle();
    check("thr_below", {31'd0, bus.o_Irq}, 32'd0);
    push(8'h03);
    idle();
    check("thr_hit", {31'd0, bus.o_Irq}, 32'd1);
    rd(2'd0);
    idle();
    check("thr_after_pop", {31'd0, bus.o_Irq}, 32'd0);
    rd(2'd0); rd(2'd0);

    // Overflow interrupt and W1C, then W1C racing a new drop
    wr(2'd2, 32'h0000_0003);
    for (int i = 0; i < 9; i++) push(8'h20 + 8'(i));
    idle();
    check("ovf_irq", {31'd0, bus.o_Irq}, 32'd1);
    wr(2'd1, 32'h4);
    idle();
    check("w1c_irq", {31'd0, bus.o_Irq}, 32'd0);
    rd(2'd1);
    check("w1c_status", bus.o_Rdata, 32'h0000_080A);
    drive(1, 8'h55, 1, 0, 1, 2'd1, 32'h4);
    rd(2'd1);
    check("w1c_vs_set", bus.o_Rdata, 32'h0000_080E);

    // Flush with a same-cycle push, then reset mid-stream
    wr(2'd2, 32'h0000_0105);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    drive(1, 8'h99, 1, 0, 1, 2'd2, 32'h0000_0105);
    rd(2'd1);
    check("flush_status", bus.o_Rdata, 32'h0000_0009);
    rd(2'd0);
    check("flush_empty", bus.o_Rdata, 32'h0);
    wr(2'd2, 32'h0000_0303);
    push(8'h61); push(8'h62); push(8'h63); rd(2'd2); idle();
    do_reset();
    check("rst_rdata", bus.o_Rdata, 32'h0);
    check("rst_irq", {31'd0, bus.o_Irq}, 32'd0);
    rd(2'd1);
    check("rst_status", bus.o_Rdata, 32'h0000_0009);
    rd(2'd2);
    check("rst_ctrl", bus.o_Rdata, 32'h0000_0101);

    // Randomized traffic against the model, two fill-pressure phases
    verbose = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 3000; i++) begin
        bit        dv, s, r, w;
        bit [1:0]  a;
        bit [31:0] wd;
        dv = ($urandom_range(99) < (ph == 0 ? 20 : 60));
        s  = ($urandom_range(99) < 60);
        r  = ($urandom_range(99) < 70);
        w  = ($urandom_range(99) < 25);
        a  = ($urandom_range(99) < 50) ? 2'd0 : 2'($urandom_range(3));
        wd = $urandom;
        wd[2] = ($urandom_range(15) == 0);
        wd[0] = ($urandom_range(7) != 0);
        i_Rst_n = ($urandom_range(499) != 0);
        drive(dv, 8'($urandom), s, r, w, a, wd);
        i_Rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
